// File: rtl/seq_pattern_detect_param.sv
// seq_pattern_detect_param: programmable serial pattern detector with Mealy pulse and saturating match counter
module seq_pattern_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         valid,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         count_clr,
  output logic                         pattern_detector,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cnt_sat
);
  localparam int LW = $clog2(PAT_W + 1);
  logic [PAT_W-2:0] r_hist;
  logic [LW-1:0]    r_fill, r_len, w_len;
  logic [PAT_W-1:0] r_pat, w_win, w_mask;
  logic             r_ovl, r_sat, w_fill_ok;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    w_win = {r_hist, din};
    w_mask = {PAT_W{1'b1}} >> (PAT_W - int'(r_len));
    w_fill_ok = ({1'b0, r_fill} + 1'b1) >= {1'b0, r_len};
    w_len = (cfg_len == '0 || cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
    pattern_detector = ~rst & valid & ~cfg_load & w_fill_ok & (((w_win ^ r_pat) & w_mask) == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= '0;
      r_len  <= LW'(PAT_W);
      r_ovl  <= 1'b1;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_len  <= w_len;
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
      end else if (valid) begin
        // a non-overlapping match consumes the bits that formed it
        if (pattern_detector && !r_ovl) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_win[PAT_W-2:0];
          r_fill <= (r_fill == LW'(PAT_W - 1)) ? r_fill : r_fill + 1'b1;
        end
      end
      if (count_clr) begin
        r_cnt <= pattern_detector ? CNT_W'(1) : '0;
        r_sat <= 1'b0;
      end else if (pattern_detector && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
        r_sat <= r_sat | (r_cnt == ~CNT_W'(1));
      end
    end
  end
  assign match_count = r_cnt;
  assign cnt_sat = r_sat;
endmodule
